// File: rtl/alarm_sequencer_module.sv
// alarm_sequencer_module
//   Latching alarm sequencer: IDLE -> ALARM (beeping, lamp on) -> SNOOZE on
//   operator acknowledge -> IDLE, or back to ALARM if the alert is still
//   present when the snooze expires. Every output is registered.
//
//   Optional feature macro: ALARM_ESCALATE_EN
//     When defined, ESC_PERIODS complete beep periods without an ack set
//     'escalated' and hold the buzzer on continuously until ack. When
//     undefined, 'escalated' is tied low and no escalation counter exists.
module alarm_sequencer_module #(
  parameter int BEEP_ON     = 4,
  parameter int BEEP_OFF    = 4,
  parameter int SNOOZE_LEN  = 16,
  parameter int ESC_PERIODS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alert,
  input  logic       ack,
  output logic       buzzer,
  output logic       led,
  output logic       alarm_active,
  output logic [1:0] state,
  output logic [3:0] event_cnt,
  output logic       escalated
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ALARM  = 2'b01,
    ST_SNOOZE = 2'b10
  } state_t;

  localparam logic [15:0] ON_LEN      = 16'(BEEP_ON);
  localparam logic [15:0] PERIOD_LAST = 16'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_LEN - 1);

  // Reject illegal parameter sets at elaboration time.
  if (BEEP_ON < 1 || BEEP_OFF < 1 || SNOOZE_LEN < 1 || ESC_PERIODS < 1) begin : g_bad_params
    $error("alarm_sequencer_module: all timing parameters must be >= 1");
  end

  state_t      cur_state;
  logic [15:0] cnt;          // beep phase in ALARM, elapsed cycles in SNOOZE
  logic [15:0] cnt_inc;
  logic        period_done;  // last cycle of a beep period
  logic        snooze_done;  // last cycle of the snooze interval
  logic        enter_alarm;  // this edge starts a new ALARM episode
  logic        esc_hold;     // buzzer forced on by escalation

  assign state = cur_state;

  // Shared decode of counter boundaries and the ALARM-entry condition.
  // NOTE: every always_comb output is assigned unconditionally, so no latch is inferred.
  always_comb begin
    cnt_inc     = cnt + 16'd1;
    period_done = (cnt == PERIOD_LAST);
    snooze_done = (cur_state == ST_SNOOZE) && (cnt == SNOOZE_LAST);
    enter_alarm = alert && ((cur_state == ST_IDLE) || snooze_done);
  end

`ifdef ALARM_ESCALATE_EN
  localparam logic [15:0] ESC_LAST = 16'(ESC_PERIODS - 1);

  logic [15:0] esc_cnt;
  logic        esc_q;
  logic        esc_hit;

  // The final unacknowledged period completes on this edge.
  assign esc_hit   = (cur_state == ST_ALARM) && !ack && !esc_q &&
                     period_done && (esc_cnt == ESC_LAST);
  assign esc_hold  = esc_q || esc_hit;
  assign escalated = esc_q;

  // Count completed beep periods; restart on every ALARM entry and on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      esc_cnt <= '0;
      esc_q   <= 1'b0;
    end else if (cur_state != ST_ALARM || ack) begin
      esc_cnt <= '0;
      esc_q   <= 1'b0;
    end else if (esc_hit) begin
      esc_q <= 1'b1;
    end else if (period_done && !esc_q) begin
      esc_cnt <= esc_cnt + 16'd1;
    end
  end
`else
  assign esc_hold  = 1'b0;
  assign escalated = 1'b0;
`endif

  // Main sequencer: state, counters and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= ST_IDLE;
      cnt          <= '0;
      buzzer       <= 1'b0;
      led          <= 1'b0;
      alarm_active <= 1'b0;
      event_cnt    <= '0;
    end else if (enter_alarm) begin
      cur_state    <= ST_ALARM;
      cnt          <= '0;
      buzzer       <= 1'b1;
      led          <= 1'b1;
      alarm_active <= 1'b1;
      if (event_cnt != 4'hF) event_cnt <= event_cnt + 4'd1;
    end else begin
      unique case (cur_state)
        ST_ALARM: begin
          if (ack) begin
            // Ack wins over any beep-phase boundary in the same cycle.
            cur_state    <= ST_SNOOZE;
            cnt          <= '0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
          end else begin
            cnt    <= period_done ? 16'd0 : cnt_inc;
            buzzer <= esc_hold || period_done || (cnt_inc < ON_LEN);
          end
        end
        ST_SNOOZE: begin
          if (snooze_done) begin
            // Alert still present was handled by enter_alarm above.
            cur_state <= ST_IDLE;
            cnt       <= '0;
            led       <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          // IDLE, and recovery from the unused 2'b11 encoding.
          cur_state    <= ST_IDLE;
          cnt          <= '0;
          buzzer       <= 1'b0;
          led          <= 1'b0;
          alarm_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sequencer_module.sv
// Testbench for alarm_sequencer_module. The reference model tracks only the
// current mode, cycles spent in it and the event count; buzzer/escalation
// are derived arithmetically from time-in-ALARM.
module tb_alarm_sequencer_module;

  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int SNZ = 16;
  localparam int ESC = 3;
  localparam int PER = ON + OFF;

  logic       clk = 1'b0;
  logic       rst, alert, ack;
  logic       buzzer, led, alarm_active, escalated;
  logic [1:0] state;
  logic [3:0] event_cnt;

  alarm_sequencer_module #(
    .BEEP_ON    (ON),
    .BEEP_OFF   (OFF),
    .SNOOZE_LEN (SNZ),
    .ESC_PERIODS(ESC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alert       (alert),
    .ack         (ack),
    .buzzer      (buzzer),
    .led         (led),
    .alarm_active(alarm_active),
    .state       (state),
    .event_cnt   (event_cnt),
    .escalated   (escalated)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=IDLE 1=ALARM 2=SNOOZE, m_t = cycles since entry.
  int m_mode = 0;
  int m_t    = 0;
  int m_ev   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_esc();
`ifdef ALARM_ESCALATE_EN
    return (m_mode == 1 && m_t >= ESC * PER) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_buz();
    if (m_mode != 1) return 0;
    return (exp_esc() == 1 || (m_t % PER) < ON) ? 1 : 0;
  endfunction

  task automatic model_enter();
    m_mode = 1;
    m_t    = 0;
    if (m_ev < 15) m_ev++;
  endtask

  task automatic model_edge(input logic r, input logic a, input logic k);
    if (r) begin
      m_mode = 0; m_t = 0; m_ev = 0;
    end else begin
      case (m_mode)
        0: if (a) model_enter();
        1: if (k) begin m_mode = 2; m_t = 0; end else m_t++;
        default: begin
          if (m_t == SNZ - 1) begin
            if (a) model_enter();
            else begin m_mode = 0; m_t = 0; end
          end else m_t++;
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("state",        {30'd0, state},        m_mode);
    check("event_cnt",    {28'd0, event_cnt},    m_ev);
    check("buzzer",       {31'd0, buzzer},       exp_buz());
    check("led",          {31'd0, led},          (m_mode != 0) ? 1 : 0);
    check("alarm_active", {31'd0, alarm_active}, (m_mode == 1) ? 1 : 0);
    check("escalated",    {31'd0, escalated},    exp_esc());
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check #1 later.
  task automatic step(input logic r, input logic a, input logic k);
    rst = r; alert = a; ack = k;
    @(posedge clk);
    model_edge(r, a, k);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; alert = 1'b0; ack = 1'b0;

    // Reset, including with alert and ack asserted.
    step(1, 0, 0);
    step(1, 1, 1);
    check("rst_state", {30'd0, state}, 0);

    // Alert entry, beep pattern, latched after alert drops at cycle 6.
    step(0, 1, 0);
    check("entry_state", {30'd0, state}, 1);
    check("entry_events", {28'd0, event_cnt}, 1);
    check("entry_buzzer", {31'd0, buzzer}, 1);
    for (int i = 2; i <= 5; i++) step(0, 1, 0);
    check("cycle5_buzzer", {31'd0, buzzer}, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    check("latched_state", {30'd0, state}, 1);

    // Ack -> SNOOZE, then expiry with alert low -> IDLE.
    step(0, 0, 1);
    check("snooze_state", {30'd0, state}, 2);
    check("snooze_buzzer", {31'd0, buzzer}, 0);
    check("snooze_led", {31'd0, led}, 1);
    for (int i = 0; i < SNZ; i++) step(0, 0, 0);
    check("expire_state", {30'd0, state}, 0);
    check("expire_led", {31'd0, led}, 0);

    // Ack during cycle 3 of a fresh ALARM episode.
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    check("ack3_state", {30'd0, state}, 2);
    for (int i = 0; i < SNZ; i++) step(0, 0, 0);

    // Alert held through snooze expiry re-enters ALARM; counter saturates.
    step(1, 0, 0);
    step(0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 1);
      for (int i = 0; i < SNZ; i++) step(0, 1, 0);
      if (k == 0) begin
        check("reentry_events", {28'd0, event_cnt}, 2);
        check("reentry_buzzer", {31'd0, buzzer}, 1);
      end
    end
    check("saturated_events", {28'd0, event_cnt}, 15);

    // Alert and ack together in IDLE enter ALARM.
    step(1, 0, 0);
    step(0, 1, 1);
    check("idle_alert_ack_state", {30'd0, state}, 1);

    // Reset in the middle of SNOOZE with alert and ack high.
    step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    step(1, 1, 1);
    check("rst_snooze_state", {30'd0, state}, 0);
    check("rst_snooze_events", {28'd0, event_cnt}, 0);
    check("rst_snooze_led", {31'd0, led}, 0);

    // Long unacknowledged ALARM: escalation if enabled, endless beeping if not.
    step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0);
`ifdef ALARM_ESCALATE_EN
    check("esc_flag", {31'd0, escalated}, 1);
    check("esc_buzzer", {31'd0, buzzer}, 1);
    step(0, 0, 1);
    check("esc_ack_flag", {31'd0, escalated}, 0);
    check("esc_ack_state", {30'd0, state}, 2);
`else
    check("noesc_flag", {31'd0, escalated}, 0);
    check("noesc_state", {30'd0, state}, 1);
    step(0, 0, 1);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3)   != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 24)  == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer_module.md
ALARM_SEQUENCER_MODULE -- requirements
Module: alarm_sequencer_module

Interface
REQ-001 The block SHALL have parameter BEEP_ON, default 4, buzzer-on cycles per beep period (legal >= 1).
REQ-002 The block SHALL have parameter BEEP_OFF, default 4, buzzer-off cycles per beep period (legal >= 1).
REQ-003 The block SHALL have parameter SNOOZE_LEN, default 16, snooze duration in cycles (legal >= 1).
REQ-004 The block SHALL have parameter ESC_PERIODS, default 3, unacknowledged full beep periods before escalation (legal >= 1).
REQ-005 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port alert  input  1  level alert from the upstream alert stage's q output.
REQ-008 The block SHALL have port ack  input  1  operator acknowledge, sampled every edge.
REQ-009 The block SHALL have port buzzer  output  1  registered beep drive.
REQ-010 The block SHALL have port led  output  1  registered alarm lamp.
REQ-011 The block SHALL have port alarm_active  output  1  high while state is ALARM.
REQ-012 The block SHALL have port state  output  2  encoding IDLE=00, ALARM=01, SNOOZE=10 (11 unused).
REQ-013 The block SHALL have port event_cnt  output  4  count of ALARM entries, saturating.
REQ-014 The block SHALL have port escalated  output  1  escalation flag (see Configuration).

Function
REQ-015 All outputs SHALL be registered; each state change is visible one edge after the sampling edge.
REQ-016 In IDLE: buzzer=0, led=0, alarm_active=0; alert=1 at an edge SHALL move to ALARM; ack is ignored.
REQ-017 Every entry into ALARM SHALL increment event_cnt by 1, saturating at 15 (no wrap).
REQ-018 In ALARM: led=1, alarm_active=1; buzzer SHALL be 1 for BEEP_ON cycles then 0 for BEEP_OFF cycles, repeating, starting with buzzer=1 in the first ALARM cycle.
REQ-019 ALARM SHALL be latched: alert falling to 0 SHALL NOT leave ALARM; only ack=1 leaves ALARM.
REQ-020 ack=1 in ALARM SHALL move to SNOOZE next edge with buzzer=0, regardless of beep phase (ack wins over a phase boundary in the same cycle).
REQ-021 In SNOOZE: buzzer=0, led=1, alarm_active=0; ack ignored; a counter runs SNOOZE_LEN cycles.
REQ-022 At SNOOZE expiry: alert=1 SHALL re-enter ALARM (counting as a new event, beep phase restarted); alert=0 SHALL go to IDLE.
REQ-023 alert=1 and ack=1 in the same IDLE cycle SHALL enter ALARM (ack ignored).
REQ-024 Internal phase/snooze counters SHALL be 16 bits and cleared on every state entry.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, buzzer=0, led=0, alarm_active=0, event_cnt=0, escalated=0, counters=0, overriding alert and ack, including mid-ALARM or mid-SNOOZE.
REQ-026 First edge after rst deasserts SHALL evaluate alert/ack normally.

Configuration
REQ-027 With ALARM_ESCALATE_EN defined, the block SHALL count completed beep periods in ALARM; on completing ESC_PERIODS periods without ack, escalated SHALL go 1 and buzzer SHALL hold 1 continuously until ack.
REQ-028 With ALARM_ESCALATE_EN defined, ack SHALL clear escalated on the same edge that enters SNOOZE; escalation count restarts on each ALARM entry.
REQ-029 Without ALARM_ESCALATE_EN, escalated SHALL be tied 0 and the beep pattern SHALL repeat indefinitely; no escalation counter is synthesized.

Verification (defaults)
REQ-030 Reset then alert=1 at edge 0 -> state=01, event_cnt=1; buzzer=1 cycles 1-4, 0 cycles 5-8, 1 from cycle 9.
REQ-031 In ALARM drop alert at cycle 6, no ack for 20 cycles -> state stays 01, beeping continues (macro off).
REQ-032 ack pulse at cycle 3 of ALARM -> next cycle state=10, buzzer=0, led=1; after 16 cycles with alert=0 -> state=00, led=0.
REQ-033 Alert held 1 through SNOOZE expiry -> re-enter ALARM, event_cnt=2, buzzer=1 first cycle; 20 such entries -> event_cnt stays 15.
REQ-034 ALARM_ESCALATE_EN defined, no ack -> escalated=1 and buzzer=1 steady from ALARM cycle 25; ack -> escalated=0, state=10.
REQ-035 rst=1 during SNOOZE with alert=1 and ack=1 -> next cycle all outputs 0, state=00, event_cnt=0.
